// File: rtl/pwm_pkg.sv
// Shared types for the PWM bank: alignment mode and counter direction.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_t;

endpackage

// File: rtl/pwm_bank_if.sv
// Control/status bundle between the register block (master) and the PWM bank (slave).
interface pwm_bank_if #(
  parameter int N        = 8,
  parameter int CHANNELS = 4
);
  logic                  step;
  logic                  restart;
  logic                  mode;
  logic [CHANNELS-1:0]   ena;
  logic [CHANNELS*N-1:0] duty;
  logic [CHANNELS-1:0]   out;
  logic                  period_start;
  logic [N-1:0]          count;

  modport master (
    output step, restart, mode, ena, duty,
    input  out, period_start, count
  );

  modport slave (
    input  step, restart, mode, ena, duty,
    output out, period_start, count
  );
endinterface

// File: rtl/pwm_timebase.sv
// Shared PWM counter: edge/center sequencing, period boundary detection and
// the shadow-load strobe that the per-channel registers follow.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic         restart,
  input  logic         mode,
  output logic [N-1:0] cnt,
  output logic         load,
  output logic         period_start
);

  localparam logic [N-1:0] CNT_TOP = {{(N-1){1'b1}}, 1'b0};

  pwm_dir_t     dir;
  pwm_dir_t     dir_nxt;
  pwm_mode_t    mode_sh;
  logic         loaded;
  logic         boundary;
  logic [N-1:0] cnt_nxt;

  always_comb begin
    boundary = (mode_sh == PWM_EDGE) ? (cnt == CNT_TOP)
                                     : (dir == DIR_DOWN && cnt == '0);
    load     = step && !restart && (boundary || !loaded);
  end

  // Both boundary kinds already leave cnt=0/dir=up, so a mode switch at a
  // boundary needs no extra path to start the new period cleanly.
  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir;
    if (mode_sh == PWM_EDGE) begin
      dir_nxt = DIR_UP;
      cnt_nxt = (cnt == CNT_TOP) ? '0 : cnt + 1'b1;
    end else if (dir == DIR_UP) begin
      if (cnt == CNT_TOP) dir_nxt = DIR_DOWN;
      else                cnt_nxt = cnt + 1'b1;
    end else begin
      if (cnt == '0) dir_nxt = DIR_UP;
      else           cnt_nxt = cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      dir          <= DIR_UP;
      mode_sh      <= PWM_EDGE;
      loaded       <= 1'b0;
      period_start <= 1'b0;
    end else begin
      period_start <= load;
      if (restart) begin
        cnt    <= '0;
        dir    <= DIR_UP;
        loaded <= 1'b0;
      end else if (step) begin
        cnt <= cnt_nxt;
        dir <= dir_nxt;
        if (load) begin
          mode_sh <= pwm_mode_t'(mode);
          loaded  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM: one shared timebase, per-channel double-buffered duty
// and a registered compare gated by the channel enable.
module pwm_bank
  import pwm_pkg::*;
#(
  parameter int N        = 8,
  parameter int CHANNELS = 4
) (
  input  logic     clk,
  input  logic     rst,
  pwm_bank_if.slave bus
);

  logic [N-1:0] cnt;
  logic         load;

  pwm_timebase #(.N(N)) u_timebase (
    .clk          (clk),
    .rst          (rst),
    .step         (bus.step),
    .restart      (bus.restart),
    .mode         (bus.mode),
    .cnt          (cnt),
    .load         (load),
    .period_start (bus.period_start)
  );

  assign bus.count = cnt;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [N-1:0] duty_sh;
    logic         cmp_q;

    // Compare uses the pre-update count and shadow, giving one step of lag.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        duty_sh <= '0;
        cmp_q   <= 1'b0;
      end else if (bus.restart) begin
        cmp_q <= 1'b0;
      end else if (bus.step) begin
        cmp_q <= (cnt < duty_sh);
        if (load) duty_sh <= bus.duty[i*N +: N];
      end
    end

    assign bus.out[i] = bus.ena[i] & cmp_q;
  end

endmodule
